// File: rtl/prio_enc_arb_if.sv
// Request/grant bundle between requesters, the priority arbiter and the shared consumer.
// The arbiter takes the slave side; the requester/consumer side takes the master side.
interface prio_enc_arb_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;

  modport master (
    output req,
    output mode,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot
  );

  modport slave (
    input  req,
    input  mode,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot
  );
endinterface

// File: rtl/prio_enc_arb.sv
// Registered N-input priority encoder / arbiter with fixed or round-robin priority.
// The presented grant stays frozen until the consumer accepts it.
module prio_enc_arb #(
  parameter int unsigned N     = 8,
  parameter bit          RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  prio_enc_arb_if.slave bus
);
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] PtrTop = W'(N - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e       state_q, state_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [W-1:0] ptr_q, ptr_d;
  // Whether the grant currently presented was chosen in round-robin mode.
  logic         rr_q, rr_d;

  logic         rr_sel;
  logic         handshake;
  logic [N-1:0] lo_mask;
  logic [N-1:0] masked;
  logic [N-1:0] cand;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;

  assign rr_sel    = RR_EN && bus.mode;
  assign handshake = (state_q == StHold) && bus.out_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (handshake && rr_q) begin
      ptr_d = (idx_q == '0) ? PtrTop : idx_q - 1'b1;
    end
  end

  // Round-robin order ptr, ptr-1, .., 0, N-1, .., ptr+1 equals: highest request at or below
  // ptr if any exists, otherwise the highest request overall.
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = (i <= int'(ptr_d));
    end
    masked  = rr_sel ? (bus.req & lo_mask) : '0;
    cand    = (masked != '0) ? masked : bus.req;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        win_idx = W'(i);
      end
    end
    win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    rr_d     = rr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req != '0) begin
          state_d  = StHold;
          valid_d  = 1'b1;
          idx_d    = win_idx;
          onehot_d = win_onehot;
          rr_d     = rr_sel;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          if (bus.req != '0) begin
            idx_d    = win_idx;
            onehot_d = win_onehot;
            rr_d     = rr_sel;
          end else begin
            state_d  = StIdle;
            valid_d  = 1'b0;
            onehot_d = '0;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= PtrTop;
      rr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
      rr_q     <= rr_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
endmodule

// File: tb/tb_prio_enc_arb.sv
// Scoreboard bench for prio_enc_arb (N=8, RR_EN=1): a behavioural model pushes the expected
// registered outputs each cycle; they are popped and compared after the clock edge.
module tb_prio_enc_arb;
  localparam int N = 8;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t sb[$];

  logic       m_valid = 1'b0;
  int         m_idx = 0;
  int         m_ptr = N - 1;
  logic       m_rr = 1'b0;
  logic [7:0] m_onehot = '0;

  prio_enc_arb_if #(.N(N)) bus ();

  prio_enc_arb #(.N(N), .RR_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_idx    = 0;
    m_ptr    = N - 1;
    m_rr     = 1'b0;
    m_onehot = '0;
  endtask

  task automatic model_grant(input logic [7:0] r, input logic md);
    bit found = 0;
    for (int k = 0; k < N; k++) begin
      int j = md ? (m_ptr - k + N) % N : N - 1 - k;
      if (!found && r[j]) begin
        found = 1;
        m_idx = j;
      end
    end
    m_valid  = 1'b1;
    m_onehot = 8'b1 << m_idx;
    m_rr     = md;
  endtask

  task automatic model_step(input logic [7:0] r, input logic md, input logic rdy);
    if (m_valid && rdy) begin
      if (m_rr) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
      if (r != 0) model_grant(r, md);
      else begin
        m_valid  = 1'b0;
        m_onehot = '0;
      end
    end else if (!m_valid && r != 0) begin
      model_grant(r, md);
    end
  endtask

  task automatic cycle(input logic [7:0] r, input logic md, input logic rdy);
    exp_t e;
    bus.req       = r;
    bus.mode      = md;
    bus.out_ready = rdy;
    model_step(r, md, rdy);
    sb.push_back('{v: m_valid, idx: 3'(m_idx), oh: m_onehot});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("valid", 64'(bus.out_valid), 64'(e.v));
    check("idx", 64'(bus.out_idx), 64'(e.idx));
    check("onehot", 64'(bus.out_onehot), 64'(e.oh));
  endtask

  initial begin
    int rr_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    bus.req       = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_idx", 64'(bus.out_idx), 64'd0);
    check("rst_onehot", 64'(bus.out_onehot), 64'd0);
    rst = 1'b0;

    // Fixed priority, constant ready: idx 5 every cycle.
    for (int i = 0; i < 4; i++) begin
      cycle(8'b0010_0110, 1'b0, 1'b1);
      check("fixed_idx", 64'(bus.out_idx), 64'd5);
      check("fixed_oh", 64'(bus.out_onehot), 64'h20);
    end

    // Round-robin sweep.
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, 1'b1, 1'b1);
      check("rr_sweep", 64'(bus.out_idx), 64'(rr_seq[i]));
    end
    cycle(8'h00, 1'b1, 1'b1);

    // Backpressure with a sticky grant whose request has dropped.
    cycle(8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b1, 1'b0);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_idx", 64'(bus.out_idx), 64'd0);
    end
    cycle(8'h00, 1'b1, 1'b1);
    check("bp_release", 64'({bus.out_valid, bus.out_onehot}), 64'd0);

    // Wrap: ptr is 7 after accepting idx 0.
    cycle(8'h81, 1'b1, 1'b1);
    check("wrap_first", 64'(bus.out_idx), 64'd7);
    cycle(8'h81, 1'b1, 1'b1);
    check("wrap_second", 64'(bus.out_idx), 64'd0);
    cycle(8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) cycle(8'h00, 1'(i % 2), 1'b1);

    // Mode toggling while holding.
    cycle(8'h14, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(8'h00, 1'(i % 2), 1'b0);
      check("mode_hold", 64'(bus.out_idx), 64'd4);
    end
    cycle(8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      cycle(8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    cycle(8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-hold.
    cycle(8'b0010_0110, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    check("pre_rst_idx", 64'(bus.out_idx), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_idx", 64'(bus.out_idx), 64'd0);
    check("arst_onehot", 64'(bus.out_onehot), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle(8'hFF, 1'b1, 1'b1);
    check("post_rst_rr", 64'(bus.out_idx), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
